// File: rtl/flpt_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : flpt_issue_ctrl
//  Purpose  : Issue/completion controller for external execution units
//             (FPU, divider, UART ...). Starts one unit per request. It then
//             waits for that unit's done line or for a fixed latency, and
//             finally emits a single writeback strobe toward the integer or
//             float register file. An op that waits too long is aborted. A
//             request to a non-existent unit is also aborted. Both aborts
//             are flagged through sticky error bits.
//  Ports    : clk, rstn            - clock, synchronous active-low reset
//             req/req_unit/req_dest- request from decode (unit, wb target)
//             unit_done            - per-unit completion lines
//             err_clr              - clears sticky error flags
//             unit_go              - one-hot start pulse to the chosen unit
//             busy                 - op in flight, requests ignored
//             done                 - one-cycle completion pulse
//             wb_int / wb_flt      - register-file write strobes
//             wb_unit              - result mux select (latched unit index)
//             timeout_err / illegal_err - sticky error flags
//  Revision : 1.0 - initial release
// ============================================================================
module flpt_issue_ctrl #(
    parameter int                NUNITS     = 4,
    parameter logic [NUNITS-1:0] FIXED_MASK = '0,
    parameter int                FIXED_LAT  = 2,
    parameter int                TIMEOUT    = 255,
    localparam int               UW         = $clog2(NUNITS)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req,
    input  logic [UW-1:0]     req_unit,
    input  logic [1:0]        req_dest,
    input  logic [NUNITS-1:0] unit_done,
    input  logic              err_clr,
    output logic [NUNITS-1:0] unit_go,
    output logic              busy,
    output logic              done,
    output logic              wb_int,
    output logic              wb_flt,
    output logic [UW-1:0]     wb_unit,
    output logic              timeout_err,
    output logic              illegal_err
);

    // The counter must reach the larger of the two limits plus one, so
    // neither comparison can be skipped by wrap-around.
    localparam int              C_MAX_WAIT  = (TIMEOUT > FIXED_LAT) ? TIMEOUT : FIXED_LAT;
    localparam int              CW          = $clog2(C_MAX_WAIT + 2);
    localparam logic [CW-1:0]   C_FIXED_LAT = CW'(FIXED_LAT);
    localparam logic [CW-1:0]   C_TIMEOUT   = CW'(TIMEOUT);
    localparam logic [CW-1:0]   C_CNT_ONE   = CW'(1);
    localparam logic [UW:0]     C_NUNITS    = (UW + 1)'(NUNITS);
    localparam logic [NUNITS-1:0] C_GO_ONE  = NUNITS'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_WB    = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [UW-1:0]   unit_q,  unit_d;
    logic [1:0]      dest_q,  dest_d;
    logic            supp_q,  supp_d;    // suppress writeback of this op
    logic [CW-1:0]   cnt_q,   cnt_d;
    logic            terr_q,  terr_d;
    logic            ierr_q,  ierr_d;

    logic            w_req_legal;
    logic            w_unit_fixed;
    logic            w_unit_fin;
    logic            w_tmo;
    logic            w_set_terr;
    logic            w_set_ierr;

    assign w_req_legal  = ({1'b0, req_unit} < C_NUNITS);
    assign w_unit_fixed = FIXED_MASK[unit_q];
    // Fixed-latency units have no done line; their completion is the count.
    assign w_unit_fin   = w_unit_fixed ? (cnt_q == C_FIXED_LAT) : unit_done[unit_q];
    // A completion arriving in the same cycle as the limit takes priority.
    assign w_tmo        = (TIMEOUT != 0) && (cnt_q == C_TIMEOUT) && !w_unit_fin;

    always_comb begin
        state_d    = state_q;
        unit_d     = unit_q;
        dest_d     = dest_q;
        supp_d     = supp_q;
        cnt_d      = cnt_q;
        w_set_terr = 1'b0;
        w_set_ierr = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (w_req_legal) begin
                        unit_d  = req_unit;
                        dest_d  = req_dest;
                        supp_d  = 1'b0;
                        state_d = ST_ISSUE;
                    end else begin
                        // Unit index and result mux stay where they were.
                        supp_d     = 1'b1;
                        w_set_ierr = 1'b1;
                        state_d    = ST_WB;
                    end
                end
            end
            ST_ISSUE: begin
                cnt_d   = C_CNT_ONE;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (w_unit_fin) begin
                    state_d = ST_WB;
                end else if (w_tmo) begin
                    supp_d     = 1'b1;
                    w_set_terr = 1'b1;
                    state_d    = ST_WB;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + C_CNT_ONE;
                end
            end
            ST_WB: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Setting has priority over a simultaneous clear.
        terr_d = (terr_q & ~err_clr) | w_set_terr;
        ierr_d = (ierr_q & ~err_clr) | w_set_ierr;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            unit_q  <= '0;
            dest_q  <= '0;
            supp_q  <= 1'b0;
            cnt_q   <= '0;
            terr_q  <= 1'b0;
            ierr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            unit_q  <= unit_d;
            dest_q  <= dest_d;
            supp_q  <= supp_d;
            cnt_q   <= cnt_d;
            terr_q  <= terr_d;
            ierr_q  <= ierr_d;
        end
    end

    // All outputs come from registered state only.
    assign unit_go     = (state_q == ST_ISSUE) ? (C_GO_ONE << unit_q) : '0;
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_WB);
    assign wb_int      = (state_q == ST_WB) && !supp_q && (dest_q == 2'd1);
    assign wb_flt      = (state_q == ST_WB) && !supp_q && (dest_q == 2'd2);
    assign wb_unit     = unit_q;
    assign timeout_err = terr_q;
    assign illegal_err = ierr_q;

endmodule
`default_nettype wire

// File: tb/tb_flpt_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_flpt_issue_ctrl
//  Purpose  : Randomized scoreboard bench for flpt_issue_ctrl. The stimulus
//             side predicts go/done events from the timing rules of the
//             controller and queues them. A monitor compares every observed
//             event against the head of the queue.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_flpt_issue_ctrl;

    localparam int             NU = 5;
    localparam logic [NU-1:0]  FM = 5'b00010;
    localparam int             FL = 3;
    localparam int             TO = 4;
    localparam int             UW = 3;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            req = 1'b0;
    logic [UW-1:0]   req_unit = '0;
    logic [1:0]      req_dest = '0;
    logic [NU-1:0]   unit_done = '0;
    logic            err_clr = 1'b0;
    logic [NU-1:0]   unit_go;
    logic            busy, done, wb_int, wb_flt, timeout_err, illegal_err;
    logic [UW-1:0]   wb_unit;

    flpt_issue_ctrl #(
        .NUNITS     (NU),
        .FIXED_MASK (FM),
        .FIXED_LAT  (FL),
        .TIMEOUT    (TO)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .req         (req),
        .req_unit    (req_unit),
        .req_dest    (req_dest),
        .unit_done   (unit_done),
        .err_clr     (err_clr),
        .unit_go     (unit_go),
        .busy        (busy),
        .done        (done),
        .wb_int      (wb_int),
        .wb_flt      (wb_flt),
        .wb_unit     (wb_unit),
        .timeout_err (timeout_err),
        .illegal_err (illegal_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int             cyc;
        logic [NU-1:0]  go;
    } go_exp_t;

    typedef struct {
        int             cyc;
        logic           wi;
        logic           wf;
        logic [UW-1:0]  unit;
        logic           chk_unit;
        logic           te;
        logic           ie;
    } done_exp_t;

    go_exp_t   go_q[$];
    done_exp_t done_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference copies of the sticky error flags.
    logic t_m = 1'b0;
    logic i_m = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Advance to the next cycle; inputs are changed 2 time units after the edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_go"},      32'(unit_go), 0);
        chk({tag, "_busy"},    32'(busy), 0);
        chk({tag, "_done"},    32'(done), 0);
        chk({tag, "_wb_int"},  32'(wb_int), 0);
        chk({tag, "_wb_flt"},  32'(wb_flt), 0);
        chk({tag, "_wb_unit"}, 32'(wb_unit), 0);
        chk({tag, "_terr"},    32'(timeout_err), 0);
        chk({tag, "_ierr"},    32'(illegal_err), 0);
    endtask

    // Monitor: every start pulse and every completion must match the queue head.
    initial begin
        go_exp_t   g;
        done_exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (unit_go != '0) begin
                if (go_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_go: got %b expected none (cycle %0d)", unit_go, cyc);
                end else begin
                    g = go_q.pop_front();
                    chk("go_cycle", 32'(cyc), 32'(g.cyc));
                    chk("go_vec", 32'(unit_go), 32'(g.go));
                    chk("busy_at_go", 32'(busy), 1);
                end
            end
            if (done || wb_int || wb_flt) begin
                if (done_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL unexpected_done: got done=%b wb_int=%b wb_flt=%b expected none (cycle %0d)",
                             done, wb_int, wb_flt, cyc);
                end else begin
                    e = done_q.pop_front();
                    chk("done_cycle", 32'(cyc), 32'(e.cyc));
                    chk("done_pulse", 32'(done), 1);
                    chk("wb_int", 32'(wb_int), 32'(e.wi));
                    chk("wb_flt", 32'(wb_flt), 32'(e.wf));
                    if (e.chk_unit) chk("wb_unit", 32'(wb_unit), 32'(e.unit));
                    chk("timeout_err", 32'(timeout_err), 32'(e.te));
                    chk("illegal_err", 32'(illegal_err), 32'(e.ie));
                end
            end
        end
    end

    // One operation: unit u, destination d, handshake delay k (done raised at
    // go+k). With noise set, spurious req and unrelated done bits are driven.
    task automatic run_txn(input int u, input int d, input int k, input bit noise, input bit clr);
        int        t, go, dn, fin, last;
        bit        legal, fixed, tmo;
        go_exp_t   g;
        done_exp_t e;

        t     = cyc;
        legal = (u < NU);
        fixed = legal && FM[u];
        req      = 1'b1;
        req_unit = UW'(u);
        req_dest = 2'(d);
        err_clr  = clr;
        if (clr) begin
            t_m = 1'b0;
            i_m = 1'b0;
        end

        if (!legal) begin
            i_m = 1'b1;
            e.cyc = t + 1; e.wi = 1'b0; e.wf = 1'b0; e.unit = '0; e.chk_unit = 1'b0;
            e.te = t_m; e.ie = i_m;
            done_q.push_back(e);
            tick();
            err_clr  = 1'b0;
            req      = noise ? 1'($urandom) : 1'b0;
            req_unit = UW'($urandom);
            tick();
            req = 1'b0;
            return;
        end

        go = t + 1;
        fin = fixed ? FL : k;
        tmo = (TO != 0) && (fin > TO);
        dn  = tmo ? (go + TO + 1) : (go + fin + 1);
        if (tmo) t_m = 1'b1;

        g.cyc = go;
        g.go  = NU'(1) << u;
        go_q.push_back(g);
        e.cyc = dn;
        e.wi  = !tmo && (d == 1);
        e.wf  = !tmo && (d == 2);
        e.unit = UW'(u);
        e.chk_unit = 1'b1;
        e.te  = t_m;
        e.ie  = i_m;
        done_q.push_back(e);

        last = (!fixed && (go + k > dn)) ? (go + k) : dn;
        while (cyc < last) begin
            tick();
            err_clr = 1'b0;
            // req driven in the writeback cycle is still ignored; later it would be taken.
            req      = (noise && cyc <= dn) ? 1'($urandom) : 1'b0;
            req_unit = UW'($urandom);
            req_dest = 2'($urandom);
            unit_done = noise ? NU'($urandom) : '0;
            if (!fixed) begin
                if (cyc > go && cyc < go + k) unit_done[u] = 1'b0;
                else if (cyc == go + k)       unit_done[u] = 1'b1;
            end
        end
        tick();
        req       = 1'b0;
        unit_done = '0;
    endtask

    task automatic clear_errs();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        t_m = 1'b0;
        i_m = 1'b0;
        chk("errclr_terr", 32'(timeout_err), 0);
        chk("errclr_ierr", 32'(illegal_err), 0);
    endtask

    // Reset while waiting: the op must vanish without done or writeback.
    task automatic reset_abort();
        go_exp_t g;
        int      go;
        go = cyc + 1;
        req = 1'b1; req_unit = 3'd0; req_dest = 2'd1;
        g.cyc = go; g.go = NU'(1);
        go_q.push_back(g);
        tick();
        req = 1'b0;
        tick();
        req = 1'b1;
        unit_done = 5'b01000;
        tick();
        req = 1'b0;
        unit_done = '0;
        rstn = 1'b0;
        tick();
        check_quiet("rst_wait");
        rstn = 1'b1;
        t_m = 1'b0;
        i_m = 1'b0;
        unit_done = '1;
        repeat (3) tick();
        unit_done = '0;
        chk("rst_late_done_busy", 32'(busy), 0);
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rstn = 1'b0;
        repeat (3) tick();
        check_quiet("reset");
        rstn = 1'b1;
        tick();

        run_txn(2, 2, 1, 1'b0, 1'b0);   // minimum handshake latency, float wb
        run_txn(1, 1, 1, 1'b0, 1'b0);   // fixed-latency unit, int wb
        run_txn(0, 1, 9, 1'b0, 1'b0);   // no done -> timeout abort
        clear_errs();
        run_txn(3, 2, TO, 1'b1, 1'b0);  // done exactly at the limit wins
        run_txn(6, 1, 1, 1'b0, 1'b0);   // non-existent unit
        run_txn(4, 3, 2, 1'b1, 1'b1);   // reserved dest, error clear with request
        run_txn(2, 1, 2, 1'b1, 1'b0);
        reset_abort();

        for (int i = 0; i < 250; i++) begin
            run_txn($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(1, 6),
                    1'($urandom), ($urandom_range(0, 3) == 0));
            if ((t_m || i_m) && ($urandom_range(0, 3) == 0)) clear_errs();
            repeat ($urandom_range(0, 2)) tick();
        end

        repeat (5) tick();
        chk("go_queue_drained", 32'(go_q.size()), 0);
        chk("done_queue_drained", 32'(done_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/flpt_issue_ctrl.md
FLPT_ISSUE_CTRL -- requirements
Module: flpt_issue_ctrl

Interface
REQ-001 SHALL have parameter NUNITS, default 4: number of variable/fixed-latency execution units (FPU, UART, divider...), 2..16.
REQ-002 SHALL have parameter FIXED_MASK, default '0: NUNITS-bit; bit u=1 means unit u has no done line and completes after FIXED_LAT cycles.
REQ-003 SHALL have parameter FIXED_LAT, default 2: completion latency for fixed units, >=1.
REQ-004 SHALL have parameter TIMEOUT, default 255: max wait cycles before abort; 0 disables timeout.
REQ-005 SHALL use one clock; reset is synchronous and active-low.
REQ-006 Ports (name direction width meaning):
- clk  in  1  clock, rising edge
- rstn  in  1  synchronous active-low reset
- req  in  1  decode stage requests external op
- req_unit  in  UW=$clog2(NUNITS)  target unit index
- req_dest  in  2  writeback target: 0 none, 1 int regfile, 2 float regfile, 3 reserved (treated as none)
- unit_done  in  NUNITS  per-unit completion pulse/level
- err_clr  in  1  clears sticky errors
- unit_go  out  NUNITS  one-hot start pulse
- busy  out  1  op in flight; req ignored
- done  out  1  one-cycle completion pulse to main FSM
- wb_int  out  1  integer regwrite strobe
- wb_flt  out  1  float regwrite strobe
- wb_unit  out  UW  result-mux select, latched unit index
- timeout_err  out  1  sticky
- illegal_err  out  1  sticky

Function
REQ-007 SHALL implement FSM states IDLE, ISSUE, WAIT, WB; all outputs decoded from registered state/latches (Moore).
REQ-008 IDLE: busy=0; req=1 with req_unit<NUNITS SHALL latch unit/dest and go to ISSUE next cycle.
REQ-009 IDLE: req=1 with req_unit>=NUNITS SHALL set illegal_err and go directly to WB with writes suppressed (done still pulses).
REQ-010 ISSUE: unit_go[unit]=1 for exactly one cycle; wait counter loaded to 1; next WAIT.
REQ-011 busy SHALL be 1 in ISSUE, WAIT, WB; req in those states SHALL be ignored, not queued.
REQ-012 WAIT, handshake unit: unit_done[unit]=1 at counter value c SHALL move to WB next cycle (done at go+k gives WB at go+k+1).
REQ-013 WAIT, fixed unit: unit_done ignored; counter==FIXED_LAT SHALL move to WB (WB at go+FIXED_LAT+1).
REQ-014 Counter SHALL increment each WAIT cycle, saturating; width sufficient for max(TIMEOUT,FIXED_LAT)+1.
REQ-015 Timeout: TIMEOUT!=0, counter==TIMEOUT, no done this cycle -> WB with writes suppressed, timeout_err set; done in same cycle wins (normal writeback).
REQ-016 unit_done bits of non-selected units, or any done outside WAIT, SHALL be ignored.
REQ-017 WB: done=1 one cycle; wb_int=1 iff dest==1 and not suppressed; wb_flt=1 iff dest==2 and not suppressed; next IDLE.
REQ-018 wb_unit SHALL hold latched unit index from ISSUE through WB and until next accepted req.
REQ-019 Minimum handshake latency: req at t, go at t+1, done at t+2, WB/done at t+3; back-to-back req accepted earliest at t+4.
REQ-020 err_clr clears both sticky errors; simultaneous set and clear -> set wins.

Reset
REQ-021 rstn=0 at a rising edge SHALL force IDLE; unit_go, busy, done, wb_int, wb_flt, wb_unit, counter, timeout_err, illegal_err = 0.
REQ-022 Reset mid-ISSUE/WAIT/WB SHALL abort silently: no further go, done or wb strobe; late unit_done after reset ignored.

Verification
REQ-023 NUNITS=4, req unit 2 dest 2 at t; unit_done[2] at t+2 -> unit_go=0100 at t+1, WB at t+3: done=1, wb_flt=1, wb_unit=2.
REQ-024 FIXED_MASK=0010, FIXED_LAT=3, req unit 1 dest 1 at t, unit_done held 0 -> go at t+1, wb_int+done at t+5.
REQ-025 TIMEOUT=4, req unit 0, no done -> done at go+5, wb_int=wb_flt=0, timeout_err=1; err_clr -> 0 next cycle.
REQ-026 NUNITS=3, req_unit=3 -> no unit_go, done next cycle with no writes, illegal_err=1.
REQ-027 req during WAIT and unit_done[3] while unit 1 selected -> both ignored; rstn=0 in WAIT -> all outputs 0 next cycle, no done.
